board_input_conditioner: RTL
============================

// Module: board_input_conditioner
// PURPOSE
//  Parametrised conditioning stage between DE2-115 pushbuttons/slide switches and game logic.
//  Per channel: 2-FF synchroniser, counter debouncer, level output, one-cycle edge pulses.
//  Keys additionally get optional auto-repeat (held paddle key -> periodic press pulses).
//  Sits directly under the board wrapper; game core consumes only conditioned signals.
// PARAMETERS
//  N_KEYS          4       number of pushbutton channels
//  N_SW            2       number of slide-switch channels
//  KEY_ACTIVE_LOW  1       1: key_raw bit 0 means pressed (DE2-115 KEY); 0: active-high
//  DEBOUNCE_CYCLES 500000  consecutive stable cycles to accept a change (10 ms @ 50 MHz), >=1
//  REPEAT_DELAY    0       cycles from accepted press to first repeat; 0 disables auto-repeat
//  REPEAT_PERIOD   2500000 cycles between subsequent repeats (>=1; ignored if REPEAT_DELAY=0)
// PORTS
//  CLOCK_50     in   1       system clock, 50 MHz
//  RESET_N      in   1       asynchronous, active-low reset
//  key_raw      in   N_KEYS  raw pushbuttons, asynchronous to CLOCK_50
//  sw_raw       in   N_SW    raw slide switches, asynchronous, active-high
//  key_level    out  N_KEYS  debounced key state, 1 = pressed
//  key_press    out  N_KEYS  1-cycle pulse: accepted press or auto-repeat tick
//  key_release  out  N_KEYS  1-cycle pulse: accepted release
//  sw_level     out  N_SW    debounced switch state
//  sw_change    out  N_SW    1-cycle pulse on any accepted switch transition
// BEHAVIOUR
//  Reset (RESET_N=0, async): all outputs 0; sync flops, debounce/repeat counters 0; states IDLE.
//  Sync: key polarity normalised (pressed=1) before 2-FF sync; sync flops reset to 0 (inactive).
//  Debounce per channel: cnt clears when sync==level; increments when sync!=level.
//   When mismatch held DEBOUNCE_CYCLES consecutive cycles, level toggles at that edge, cnt->0.
//   Single-cycle agreement during counting clears cnt (glitch rejected, no output change).
//   Latency raw->level: 2 sync cycles + DEBOUNCE_CYCLES cycles.
//  Pulses: registered, asserted on the same edge level changes, high exactly 1 cycle.
//  Switch on at reset release: sw_level rises after normal latency with one sw_change pulse.
//  Counter width: $clog2(max(DEBOUNCE_CYCLES,REPEAT_DELAY,REPEAT_PERIOD)+1); no wrap.
//  Auto-repeat FSM per key (REPEAT_DELAY>0), rcnt per key:
//   IDLE   : level rise -> press pulse, rcnt=0, go DELAY.
//   DELAY  : rcnt++; after REPEAT_DELAY cycles still held -> press pulse, rcnt=0, go REPEAT.
//   REPEAT : rcnt++; every REPEAT_PERIOD cycles -> press pulse, rcnt=0.
//   Any state, level fall -> release pulse, go IDLE; release wins, no press same cycle.
//  REPEAT_DELAY=0: FSM stays IDLE; one press per accepted press, nothing while held.
//  Channels fully independent; simultaneous events on different channels all reported same cycle.
//  Reset mid-press/mid-repeat: outputs drop immediately; after release, still-held key is
//   re-accepted after full latency with a fresh press pulse.
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, KEY_ACTIVE_LOW=1)
//  Reset: RESET_N=0 mid-operation -> all outputs 0 same cycle, before any clock edge.
//  Clean press: key_raw[0] 1->0 held -> key_level[0]=1 and key_press[0] pulse 6 cycles later.
//  Bounce: key_raw[1] low 3 cycles, high 1, low 3 -> no level change, no pulses.
//  Repeat: key_raw[2] held low 30 cycles -> presses at t0, t0+10, t0+13, t0+16...; one release on let-go.
//  Release/repeat clash: release accepted on repeat-due cycle -> key_release only, key_press 0.
//  Switch: sw_raw=2'b11 during reset, release -> sw_level=11 with one sw_change=11 pulse at cycle 6.

Source files
------------

// File: rtl/board_input_conditioner.sv
// Conditions DE2-115 pushbuttons and slide switches for game logic: 2-FF synchronisers,
// counter debouncers, registered level/edge outputs, and optional key auto-repeat.
module board_input_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 2,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic [N_SW-1:0]   sw_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_SW-1:0]   sw_level,
    output logic [N_SW-1:0]   sw_change
);

    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST = CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
    localparam bit            REPEAT_EN = (REPEAT_DELAY > 0);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rep_state_t;

    logic [N_KEYS-1:0] key_norm, key_s1, key_s2;
    logic [N_SW-1:0]   sw_s1, sw_s2;

    logic [N_KEYS-1:0] key_level_d, key_rise, key_fall, key_press_d, key_release_d;
    logic [N_SW-1:0]   sw_level_d;

    logic [CW-1:0] key_cnt_q [N_KEYS];
    logic [CW-1:0] key_cnt_d [N_KEYS];
    logic [CW-1:0] sw_cnt_q  [N_SW];
    logic [CW-1:0] sw_cnt_d  [N_SW];
    logic [CW-1:0] rcnt_q    [N_KEYS];
    logic [CW-1:0] rcnt_d    [N_KEYS];
    rep_state_t    state_q   [N_KEYS];
    rep_state_t    state_d   [N_KEYS];

    // Keys are normalised to pressed=1 before synchronising, so everything downstream is active-high
    assign key_norm = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;

    always_comb begin
        key_level_d = key_level;
        for (int i = 0; i < N_KEYS; i++) begin
            key_cnt_d[i] = '0;
            if (key_s2[i] != key_level[i]) begin
                if (key_cnt_q[i] == DB_LAST) key_level_d[i] = ~key_level[i];
                else                         key_cnt_d[i]   = key_cnt_q[i] + ONE;
            end
        end
    end

    always_comb begin
        sw_level_d = sw_level;
        for (int i = 0; i < N_SW; i++) begin
            sw_cnt_d[i] = '0;
            if (sw_s2[i] != sw_level[i]) begin
                if (sw_cnt_q[i] == DB_LAST) sw_level_d[i] = ~sw_level[i];
                else                        sw_cnt_d[i]   = sw_cnt_q[i] + ONE;
            end
        end
    end

    assign key_rise = key_level_d & ~key_level;
    assign key_fall = ~key_level_d & key_level;

    // Auto-repeat: a release always takes priority over a press that falls due the same cycle
    always_comb begin
        key_press_d   = '0;
        key_release_d = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            state_d[i] = state_q[i];
            rcnt_d[i]  = rcnt_q[i];
            if (key_fall[i]) begin
                key_release_d[i] = 1'b1;
                state_d[i]       = ST_IDLE;
                rcnt_d[i]        = '0;
            end else if (key_rise[i]) begin
                key_press_d[i] = 1'b1;
                rcnt_d[i]      = '0;
                state_d[i]     = REPEAT_EN ? ST_DELAY : ST_IDLE;
            end else begin
                case (state_q[i])
                    ST_DELAY: begin
                        if (rcnt_q[i] == RD_LAST) begin
                            key_press_d[i] = 1'b1;
                            rcnt_d[i]      = '0;
                            state_d[i]     = ST_REPEAT;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + ONE;
                        end
                    end
                    ST_REPEAT: begin
                        if (rcnt_q[i] == RP_LAST) begin
                            key_press_d[i] = 1'b1;
                            rcnt_d[i]      = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + ONE;
                        end
                    end
                    default: rcnt_d[i] = '0;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_s1      <= '0;
            key_s2      <= '0;
            sw_s1       <= '0;
            sw_s2       <= '0;
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            sw_level    <= '0;
            sw_change   <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                key_cnt_q[i] <= '0;
                rcnt_q[i]    <= '0;
                state_q[i]   <= ST_IDLE;
            end
            for (int i = 0; i < N_SW; i++) begin
                sw_cnt_q[i] <= '0;
            end
        end else begin
            key_s1      <= key_norm;
            key_s2      <= key_s1;
            sw_s1       <= sw_raw;
            sw_s2       <= sw_s1;
            key_level   <= key_level_d;
            key_press   <= key_press_d;
            key_release <= key_release_d;
            sw_level    <= sw_level_d;
            sw_change   <= sw_level_d ^ sw_level;
            for (int i = 0; i < N_KEYS; i++) begin
                key_cnt_q[i] <= key_cnt_d[i];
                rcnt_q[i]    <= rcnt_d[i];
                state_q[i]   <= state_d[i];
            end
            for (int i = 0; i < N_SW; i++) begin
                sw_cnt_q[i] <= sw_cnt_d[i];
            end
        end
    end

endmodule
